// File: rtl/qpu_lsu_agu.sv
// qpu_lsu_agu: load/store AGU with LSU command build and response tracking; QPU_AGU_MISALGN_CHK_EN enables the misalignment exception path
module qpu_lsu_agu #(
  parameter int XLEN = 32,
  parameter int ADDR_SIZE = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 agu_i_valid,
  output logic                 agu_i_ready,
  input  logic                 agu_i_load,
  input  logic [1:0]           agu_i_size,
  input  logic                 agu_i_usign,
  input  logic [XLEN-1:0]      agu_i_rs1,
  input  logic [XLEN-1:0]      agu_i_rs2,
  input  logic [11:0]          agu_i_imm,
  input  logic [4:0]           agu_i_rd_idx,
  output logic                 lsu_icb_cmd_valid,
  input  logic                 lsu_icb_cmd_ready,
  output logic [ADDR_SIZE-1:0] lsu_icb_cmd_addr,
  output logic                 lsu_icb_cmd_read,
  output logic [XLEN-1:0]      lsu_icb_cmd_wdata,
  output logic [XLEN/8-1:0]    lsu_icb_cmd_wmask,
  input  logic                 lsu_o_valid,
  output logic                 lsu_o_ready,
  input  logic [XLEN-1:0]      lsu_o_wbck_rdata,
  output logic                 wbck_o_valid,
  input  logic                 wbck_o_ready,
  output logic [XLEN-1:0]      wbck_o_wdat,
  output logic [4:0]           wbck_o_rdidx,
  output logic                 excp_o_valid,
  input  logic                 excp_o_ready,
  output logic [ADDR_SIZE-1:0] excp_o_badaddr,
  output logic                 excp_o_ld,
  output logic                 agu_o_orphan,
  output logic                 agu_active
);
  localparam int AW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  logic [ADDR_SIZE-1:0] ea_raw, ea;
  logic [1:0] off;
  logic is_byte, is_half, is_word, mis, full, empty, push, pop;
  logic [AW:0] wp, rp, cnt;
  logic [10:0] mem [2**AW];
  logic [10:0] head;
  logic [XLEN-1:0] sh;
  assign is_byte = agu_i_size == 2'b00;
  assign is_half = agu_i_size == 2'b01;
  assign is_word = agu_i_size[1];
  assign ea_raw = agu_i_rs1[ADDR_SIZE-1:0] + {{(ADDR_SIZE-12){agu_i_imm[11]}}, agu_i_imm};
`ifdef QPU_AGU_MISALGN_CHK_EN
  assign ea = ea_raw;
  assign mis = is_half ? ea_raw[0] : is_word & (ea_raw[1:0] != 2'b00);
  always_ff @(posedge clk) begin
    if (rst) begin
      excp_o_valid <= 1'b0;
      excp_o_badaddr <= '0;
      excp_o_ld <= 1'b0;
    end else if (excp_o_valid) begin
      excp_o_valid <= !excp_o_ready;
    end else if (agu_i_valid & mis) begin
      excp_o_valid <= 1'b1;
      excp_o_badaddr <= ea;
      excp_o_ld <= agu_i_load;
    end
  end
`else
  // Misaligned ops are silently rounded down to natural alignment
  assign ea = is_word ? {ea_raw[ADDR_SIZE-1:2], 2'b00} : is_half ? {ea_raw[ADDR_SIZE-1:1], 1'b0} : ea_raw;
  assign mis = 1'b0;
  assign excp_o_valid = 1'b0 & excp_o_ready;
  assign excp_o_badaddr = '0;
  assign excp_o_ld = 1'b0;
`endif
  assign off = ea[1:0];
  assign full = cnt == (AW+1)'(OUTS_DEPTH);
  assign empty = cnt == '0;
  assign lsu_icb_cmd_valid = agu_i_valid & !full & !excp_o_valid & !mis;
  assign agu_i_ready = mis ? agu_i_valid & !excp_o_valid : lsu_icb_cmd_valid & lsu_icb_cmd_ready;
  assign lsu_icb_cmd_addr = ea;
  assign lsu_icb_cmd_read = agu_i_load;
  assign lsu_icb_cmd_wdata = is_byte ? {4{agu_i_rs2[7:0]}} : is_half ? {2{agu_i_rs2[15:0]}} : agu_i_rs2;
  assign lsu_icb_cmd_wmask = is_byte ? 4'b0001 << off : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign push = lsu_icb_cmd_valid & lsu_icb_cmd_ready;
  // head layout: {load, size[1:0], usign, off[1:0], rd[4:0]}
  assign head = mem[rp[AW-1:0]];
  assign lsu_o_ready = empty | !head[10] | wbck_o_ready;
  assign wbck_o_valid = !empty & head[10] & lsu_o_valid;
  assign pop = !empty & lsu_o_valid & lsu_o_ready;
  assign sh = lsu_o_wbck_rdata >> {head[6:5], 3'b000};
  assign wbck_o_wdat = head[9] ? sh
                     : head[8] ? {{16{~head[7] & sh[15]}}, sh[15:0]}
                     : {{24{~head[7] & sh[7]}}, sh[7:0]};
  assign wbck_o_rdidx = head[4:0];
  assign agu_active = !empty | excp_o_valid | agu_i_valid;
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= {agu_i_load, agu_i_size, agu_i_usign, off, agu_i_rd_idx};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      agu_o_orphan <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      agu_o_orphan <= lsu_o_valid & empty;
    end
  end
endmodule

// File: tb/tb_qpu_lsu_agu.sv
// tb_qpu_lsu_agu: scoreboard bench for qpu_lsu_agu; exercises QPU_AGU_MISALGN_CHK_EN either way
module tb_qpu_lsu_agu;
  logic clk = 0, rst = 1;
  logic agu_i_valid = 0, agu_i_ready, agu_i_load = 0, agu_i_usign = 0;
  logic [1:0] agu_i_size = 0;
  logic [31:0] agu_i_rs1 = 0, agu_i_rs2 = 0;
  logic [11:0] agu_i_imm = 0;
  logic [4:0] agu_i_rd_idx = 0;
  logic lsu_icb_cmd_valid, lsu_icb_cmd_ready = 0, lsu_icb_cmd_read;
  logic [31:0] lsu_icb_cmd_addr, lsu_icb_cmd_wdata;
  logic [3:0] lsu_icb_cmd_wmask;
  logic lsu_o_valid = 0, lsu_o_ready;
  logic [31:0] lsu_o_wbck_rdata = 0;
  logic wbck_o_valid, wbck_o_ready = 0;
  logic [31:0] wbck_o_wdat;
  logic [4:0] wbck_o_rdidx;
  logic excp_o_valid, excp_o_ready = 0, excp_o_ld, agu_o_orphan, agu_active;
  logic [31:0] excp_o_badaddr;
  int checks = 0, failures = 0;
  typedef struct packed {logic load; logic [1:0] size; logic usign; logic [1:0] off; logic [4:0] rd;} op_t;
  op_t sb[$];

  qpu_lsu_agu dut (
    .clk(clk), .rst(rst),
    .agu_i_valid(agu_i_valid), .agu_i_ready(agu_i_ready), .agu_i_load(agu_i_load),
    .agu_i_size(agu_i_size), .agu_i_usign(agu_i_usign), .agu_i_rs1(agu_i_rs1),
    .agu_i_rs2(agu_i_rs2), .agu_i_imm(agu_i_imm), .agu_i_rd_idx(agu_i_rd_idx),
    .lsu_icb_cmd_valid(lsu_icb_cmd_valid), .lsu_icb_cmd_ready(lsu_icb_cmd_ready),
    .lsu_icb_cmd_addr(lsu_icb_cmd_addr), .lsu_icb_cmd_read(lsu_icb_cmd_read),
    .lsu_icb_cmd_wdata(lsu_icb_cmd_wdata), .lsu_icb_cmd_wmask(lsu_icb_cmd_wmask),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready), .lsu_o_wbck_rdata(lsu_o_wbck_rdata),
    .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready), .wbck_o_wdat(wbck_o_wdat),
    .wbck_o_rdidx(wbck_o_rdidx), .excp_o_valid(excp_o_valid), .excp_o_ready(excp_o_ready),
    .excp_o_badaddr(excp_o_badaddr), .excp_o_ld(excp_o_ld), .agu_o_orphan(agu_o_orphan),
    .agu_active(agu_active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_ea(input logic [1:0] size, input logic [31:0] rs1, input logic [11:0] imm);
    logic [31:0] e;
    e = rs1 + {{20{imm[11]}}, imm};
`ifndef QPU_AGU_MISALGN_CHK_EN
    if (size[1]) e[1:0] = 2'b00;
    else if (size == 2'b01) e[0] = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] exp_load(input op_t o, input logic [31:0] rdata);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
    if (o.size[1]) return rdata;
    if (o.size == 2'b00) return {{24{~o.usign & b[o.off][7]}}, b[o.off]};
    return {{16{~o.usign & b[o.off+1][7]}}, b[o.off+1], b[o.off]};
  endfunction

  task automatic drive_op(input logic load, input logic [1:0] size, input logic usign,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [11:0] imm, input logic [4:0] rd);
    agu_i_valid = 1; agu_i_load = load; agu_i_size = size; agu_i_usign = usign;
    agu_i_rs1 = rs1; agu_i_rs2 = rs2; agu_i_imm = imm; agu_i_rd_idx = rd;
  endtask

  task automatic push_op(input logic load, input logic [1:0] size, input logic usign, input logic [31:0] ea, input logic [4:0] rd);
    op_t o;
    o.load = load; o.size = size; o.usign = usign; o.off = ea[1:0]; o.rd = rd;
    sb.push_back(o);
  endtask

  task automatic issue(input logic load, input logic [1:0] size, input logic usign,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [11:0] imm, input logic [4:0] rd);
    logic [31:0] ea, wd;
    logic [3:0] m;
    int n;
    ea = exp_ea(size, rs1, imm);
    for (int i = 0; i < 4; i++) m[i] = size[1] | ((size == 2'b00) ? (i == int'(ea[1:0])) : (i / 2 == int'(ea[1])));
    wd = (size == 2'b00) ? {4{rs2[7:0]}} : (size == 2'b01) ? {2{rs2[15:0]}} : rs2;
    drive_op(load, size, usign, rs1, rs2, imm, rd);
    lsu_icb_cmd_ready = 1;
    #1;
    checks++;
    if (lsu_icb_cmd_valid !== 1'b1 || lsu_icb_cmd_addr !== ea || lsu_icb_cmd_read !== load) begin
      failures++;
      $display("FAIL issue_cmd: valid=%b addr=%h read=%b, want valid=1 addr=%h read=%b",
               lsu_icb_cmd_valid, lsu_icb_cmd_addr, lsu_icb_cmd_read, ea, load);
    end
    checks++;
    if (lsu_icb_cmd_wdata !== wd || lsu_icb_cmd_wmask !== m) begin
      failures++;
      $display("FAIL issue_data: wdata=%h wmask=%b, want wdata=%h wmask=%b", lsu_icb_cmd_wdata, lsu_icb_cmd_wmask, wd, m);
    end
    n = 0;
    while (agu_i_ready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (agu_i_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready: agu_i_ready=%b after %0d cycles, want 1", agu_i_ready, n);
    end else push_op(load, size, usign, ea, rd);
    tick();
    agu_i_valid = 0;
    lsu_icb_cmd_ready = 0;
  endtask

  task automatic respond(input logic [31:0] rdata, input logic wr);
    op_t o;
    logic [31:0] e;
    lsu_o_valid = 1; lsu_o_wbck_rdata = rdata; wbck_o_ready = wr;
    #1;
    if (sb.size() == 0) begin
      checks++;
      if (lsu_o_ready !== 1'b1 || wbck_o_valid !== 1'b0) begin
        failures++;
        $display("FAIL orphan_rsp: lsu_o_ready=%b wbck_o_valid=%b, want 1 0", lsu_o_ready, wbck_o_valid);
      end
      tick();
      lsu_o_valid = 0;
      checks++;
      if (agu_o_orphan !== 1'b1) begin failures++; $display("FAIL orphan_pulse: got %b want 1", agu_o_orphan); end
      tick();
      checks++;
      if (agu_o_orphan !== 1'b0) begin failures++; $display("FAIL orphan_clear: got %b want 0", agu_o_orphan); end
    end else begin
      o = sb.pop_front();
      checks++;
      if (wbck_o_valid !== o.load || lsu_o_ready !== 1'b1) begin
        failures++;
        $display("FAIL rsp_hs: wbck_o_valid=%b lsu_o_ready=%b, want %b 1", wbck_o_valid, lsu_o_ready, o.load);
      end
      if (o.load) begin
        e = exp_load(o, rdata);
        checks++;
        if (wbck_o_wdat !== e || wbck_o_rdidx !== o.rd) begin
          failures++;
          $display("FAIL rsp_data: wdat=%h rd=%0d, want wdat=%h rd=%0d", wbck_o_wdat, wbck_o_rdidx, e, o.rd);
        end
      end
      tick();
      lsu_o_valid = 0;
      wbck_o_ready = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    #1;
    checks++;
    if (wbck_o_valid !== 0 || excp_o_valid !== 0 || agu_o_orphan !== 0 || agu_active !== 0 || lsu_icb_cmd_valid !== 0 || lsu_o_ready !== 1) begin
      failures++;
      $display("FAIL reset_state: wbck=%b excp=%b orphan=%b active=%b cmd=%b lsu_rdy=%b, want 0 0 0 0 0 1",
               wbck_o_valid, excp_o_valid, agu_o_orphan, agu_active, lsu_icb_cmd_valid, lsu_o_ready);
    end
    drive_op(1, 2'b10, 0, 32'h0, 32'h0, 12'h0, 5'd1);
    #1;
    checks++;
    if (lsu_icb_cmd_valid !== 1 || agu_i_ready !== 0 || agu_active !== 1) begin
      failures++;
      $display("FAIL reset_cmd: cmd_valid=%b ready=%b active=%b, want 1 0 1", lsu_icb_cmd_valid, agu_i_ready, agu_active);
    end
    agu_i_valid = 0;
    tick();
  endtask

  task automatic test_word_load();
    issue(1, 2'b10, 0, 32'h100, 32'h0, 12'h004, 5'd5);
    lsu_o_valid = 1; lsu_o_wbck_rdata = 32'hDEADBEEF; wbck_o_ready = 0;
    #1;
    checks++;
    if (wbck_o_valid !== 1 || lsu_o_ready !== 0) begin
      failures++;
      $display("FAIL wbck_stall: wbck_o_valid=%b lsu_o_ready=%b, want 1 0", wbck_o_valid, lsu_o_ready);
    end
    tick();
    respond(32'hDEADBEEF, 1);
  endtask

  task automatic test_sub_word();
    issue(1, 2'b00, 0, 32'h204, 32'h0, 12'hFFF, 5'd6);
    respond(32'h80112233, 1);
    issue(1, 2'b00, 1, 32'h204, 32'h0, 12'hFFF, 5'd7);
    respond(32'h80112233, 1);
    issue(1, 2'b01, 0, 32'h200, 32'h0, 12'h002, 5'd8);
    respond(32'h9ABC0000, 1);
    issue(0, 2'b01, 0, 32'h200, 32'h1234ABCD, 12'h002, 5'd0);
    respond(32'h0, 0);
    issue(0, 2'b00, 0, 32'h201, 32'h000000A5, 12'h000, 5'd0);
    respond(32'h0, 0);
  endtask

  task automatic test_full();
    issue(1, 2'b10, 0, 32'h300, 32'h0, 12'h000, 5'd1);
    issue(1, 2'b00, 1, 32'h301, 32'h0, 12'h000, 5'd2);
    drive_op(1, 2'b01, 0, 32'h302, 32'h0, 12'h000, 5'd3);
    lsu_icb_cmd_ready = 1;
    #1;
    checks++;
    if (agu_i_ready !== 0 || lsu_icb_cmd_valid !== 0) begin
      failures++;
      $display("FAIL full_block: ready=%b cmd_valid=%b, want 0 0", agu_i_ready, lsu_icb_cmd_valid);
    end
    lsu_o_valid = 1; lsu_o_wbck_rdata = 32'h8899AABB; wbck_o_ready = 1;
    #1;
    checks++;
    if (agu_i_ready !== 0) begin failures++; $display("FAIL full_nobypass: ready=%b want 0", agu_i_ready); end
    begin
      op_t o = sb.pop_front();
      checks++;
      if (wbck_o_valid !== 1 || wbck_o_wdat !== exp_load(o, 32'h8899AABB) || wbck_o_rdidx !== o.rd) begin
        failures++;
        $display("FAIL full_pop: valid=%b wdat=%h rd=%0d, want 1 %h %0d", wbck_o_valid, wbck_o_wdat, wbck_o_rdidx,
                 exp_load(o, 32'h8899AABB), o.rd);
      end
    end
    tick();
    lsu_o_valid = 0;
    #1;
    checks++;
    if (agu_i_ready !== 1) begin failures++; $display("FAIL full_resume: ready=%b want 1", agu_i_ready); end
    else push_op(1, 2'b01, 0, 32'h302, 5'd3);
    tick();
    agu_i_valid = 0; lsu_icb_cmd_ready = 0;
    respond(32'h8899AABB, 1);
    respond(32'h8899AABB, 1);
  endtask

  task automatic test_misalign();
`ifdef QPU_AGU_MISALGN_CHK_EN
    excp_o_ready = 0;
    drive_op(1, 2'b10, 0, 32'h100, 32'h0, 12'h002, 5'd7);
    lsu_icb_cmd_ready = 1;
    #1;
    checks++;
    if (lsu_icb_cmd_valid !== 0 || agu_i_ready !== 1) begin
      failures++;
      $display("FAIL mis_accept: cmd_valid=%b ready=%b, want 0 1", lsu_icb_cmd_valid, agu_i_ready);
    end
    tick();
    agu_i_valid = 0;
    #1;
    checks++;
    if (excp_o_valid !== 1 || excp_o_badaddr !== 32'h102 || excp_o_ld !== 1 || agu_active !== 1) begin
      failures++;
      $display("FAIL mis_excp: valid=%b badaddr=%h ld=%b active=%b, want 1 00000102 1 1",
               excp_o_valid, excp_o_badaddr, excp_o_ld, agu_active);
    end
    drive_op(1, 2'b10, 0, 32'h400, 32'h0, 12'h000, 5'd8);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (agu_i_ready !== 0 || lsu_icb_cmd_valid !== 0 || excp_o_valid !== 1) begin
        failures++;
        $display("FAIL mis_stall: cycle=%0d ready=%b cmd=%b excp=%b, want 0 0 1", i, agu_i_ready, lsu_icb_cmd_valid, excp_o_valid);
      end
      tick();
    end
    excp_o_ready = 1;
    #1;
    checks++;
    if (agu_i_ready !== 0) begin failures++; $display("FAIL mis_ack_cycle: ready=%b want 0", agu_i_ready); end
    tick();
    excp_o_ready = 0;
    #1;
    checks++;
    if (excp_o_valid !== 0 || agu_i_ready !== 1 || lsu_icb_cmd_addr !== 32'h400) begin
      failures++;
      $display("FAIL mis_release: excp=%b ready=%b addr=%h, want 0 1 00000400", excp_o_valid, agu_i_ready, lsu_icb_cmd_addr);
    end else push_op(1, 2'b10, 0, 32'h400, 5'd8);
    tick();
    agu_i_valid = 0; lsu_icb_cmd_ready = 0;
    respond(32'h11223344, 1);
`else
    issue(1, 2'b10, 0, 32'h100, 32'h0, 12'h002, 5'd7);
    checks++;
    if (excp_o_valid !== 0 || excp_o_badaddr !== 0 || excp_o_ld !== 0) begin
      failures++;
      $display("FAIL align_noexcp: valid=%b badaddr=%h ld=%b, want 0 0 0", excp_o_valid, excp_o_badaddr, excp_o_ld);
    end
    respond(32'h11223344, 1);
    issue(1, 2'b01, 0, 32'h200, 32'h0, 12'h003, 5'd9);
    respond(32'hCAFE1234, 1);
`endif
  endtask

  task automatic test_reset_mid();
    issue(1, 2'b10, 0, 32'h500, 32'h0, 12'h000, 5'd4);
    rst = 1;
    tick();
    rst = 0;
    sb.delete();
    #1;
    checks++;
    if (agu_active !== 0 || wbck_o_valid !== 0) begin
      failures++;
      $display("FAIL reset_mid: active=%b wbck=%b, want 0 0", agu_active, wbck_o_valid);
    end
    respond(32'h12345678, 1);
  endtask

  task automatic test_back_to_back();
    issue(1, 2'b10, 0, 32'h600, 32'h0, 12'h000, 5'd10);
    issue(0, 2'b10, 0, 32'h604, 32'hA5A5A5A5, 12'h000, 5'd0);
    respond(32'h01020304, 1);
    issue(1, 2'b01, 1, 32'h608, 32'h0, 12'h7FE, 5'd11);
    respond(32'h0, 0);
    respond(32'hFEDC8765, 1);
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_sub_word();
    test_full();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qpu_lsu_agu.md
Name: qpu_lsu_agu

Overview:
- Load/store address-generation and response-tracking stage, directly upstream of the QPU LSU/DTCM subsystem.
- Accepts decoded load/store ops from the EXU and computes the effective address (rs1 + sign-extended imm).
- Checks alignment, then builds the LSU ICB command: address, read flag, lane-replicated wdata and byte wmask.
- Records each issued op in an outstanding FIFO so that LSU write-back responses are lane-extracted, sign/zero-extended and returned with their rd index.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- ADDR_SIZE, 32, effective-address width.
- OUTS_DEPTH, 2, outstanding-FIFO entries; must be a power of 2 and at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- agu_i_valid  in  1  op valid
- agu_i_ready  out  1  op accepted
- agu_i_load  in  1  1 = load, 0 = store
- agu_i_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- agu_i_usign  in  1  zero-extend the load result
- agu_i_rs1  in  XLEN  base address
- agu_i_rs2  in  XLEN  store data
- agu_i_imm  in  12  signed offset
- agu_i_rd_idx  in  5  load destination register
- lsu_icb_cmd_valid  out  1  command valid to LSU
- lsu_icb_cmd_ready  in  1  LSU accepts command
- lsu_icb_cmd_addr  out  ADDR_SIZE  effective address
- lsu_icb_cmd_read  out  1  equals agu_i_load
- lsu_icb_cmd_wdata  out  XLEN  replicated store data
- lsu_icb_cmd_wmask  out  XLEN/8  byte enables
- lsu_o_valid  in  1  LSU response valid
- lsu_o_ready  out  1  response consumed
- lsu_o_wbck_rdata  in  XLEN  raw read word
- wbck_o_valid  out  1  load result valid
- wbck_o_ready  in  1  write-back port accepts
- wbck_o_wdat  out  XLEN  extended load data
- wbck_o_rdidx  out  5  destination register
- excp_o_valid  out  1  misalignment exception (registered)
- excp_o_ready  in  1  exception accepted
- excp_o_badaddr  out  ADDR_SIZE  faulting address
- excp_o_ld  out  1  1 = faulting op was a load
- agu_o_orphan  out  1  one-cycle pulse when a response arrives with the FIFO empty
- agu_active  out  1  FIFO non-empty, or excp_o_valid, or agu_i_valid

Behaviour:
- Effective address: ea = rs1 + sext(imm), modulo 2^ADDR_SIZE. Byte offset off = ea[1:0].
- Misaligned when: half with off[0] = 1; word with off != 0.
- Aligned op, issue path (combinational pass-through):
  - lsu_icb_cmd_valid = agu_i_valid & !full & !excp_o_valid.
  - agu_i_ready = lsu_icb_cmd_valid & lsu_icb_cmd_ready.
  - On handshake, push {load, size, usign, off, rd_idx}.
- Misaligned op:
  - No command is issued.
  - If excp_o_valid = 0, the op is accepted (agu_i_ready = 1) and next cycle excp_o_valid = 1 with badaddr = ea and ld = load.
  - excp_o_valid holds until excp_o_ready. While it is held, agu_i_ready = 0.
- wdata: byte = {4{rs2[7:0]}}, half = {2{rs2[15:0]}}, word = rs2.
- wmask: byte = 4'b0001 << off; half = off[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
- On loads, wdata and wmask are don't-care, but are driven by the same rules.
- Response path, head entry is a load:
  - wbck_o_valid = lsu_o_valid; lsu_o_ready = wbck_o_ready.
  - wbck_o_wdat = lane = rdata >> (8*off); byte/half result is sign-extended unless usign.
  - Pop on lsu_o_valid & wbck_o_ready.
- Response path, head entry is a store: lsu_o_ready = 1, wbck_o_valid = 0, pop on lsu_o_valid.
- FIFO empty and lsu_o_valid: lsu_o_ready = 1, the response is dropped and agu_o_orphan pulses.
- FIFO full: no push, even if a pop occurs in the same cycle (no full bypass). When not full, push and pop may happen in the same cycle; count is unchanged.
- Pointers are log2(OUTS_DEPTH) bits wide, plus a wrap bit. Full = pointers equal with wrap bits differing.
- Reset values:
  - Pointers, count and excp_o_valid = 0; agu_o_orphan = 0.
  - Therefore wbck_o_valid = 0 and lsu_icb_cmd_valid depends only on agu_i_valid.
  - Reset mid-operation discards all outstanding entries; later responses are reported as orphans.
- Latency: command has 0 cycles from input; exception has 1 cycle; write-back has 0 cycles from lsu_o_valid.

Optional Feature:
- Macro QPU_AGU_MISALGN_CHK_EN.
- Defined: misalignment handling as described above.
- Undefined:
  - No exception path. excp_o_valid is tied to 0 and badaddr/ld to 0.
  - Misaligned addresses are forced to natural alignment (half clears ea[0], word clears ea[1:0]) before wmask/off computation and issue.

Test Plan:
- Word load, rs1 = 0x100, imm = 4, rsp rdata = 0xDEADBEEF, rd = 5 -> cmd addr 0x104, read = 1; wbck_o_wdat 0xDEADBEEF, rdidx 5.
- Signed byte load at ea 0x203, rdata = 0x80112233 -> wmask-independent; wbck_o_wdat 0xFFFFFF80. Same op with usign = 1 -> 0x00000080.
- Half store rs2 = 0x1234ABCD at ea 0x202 -> wdata 0xABCDABCD, wmask 4'b1100. Response is popped with no wbck_o_valid.
- OUTS_DEPTH = 2, lsu_o_valid held 0, three ops offered -> two accepted; third has agu_i_ready = 0 until one response pops (a pop in the full cycle still blocks the push).
- With the macro defined, word load at ea 0x102 -> no cmd; next cycle excp_o_valid = 1, badaddr 0x102, ld = 1. Hold excp_o_ready = 0 for 3 cycles -> the next op stalls. Macro undefined -> cmd addr 0x100, wmask 4'b1111.
- Issue a load, assert rst for 1 cycle, then lsu_o_valid = 1 -> lsu_o_ready = 1, wbck_o_valid = 0, agu_o_orphan pulses once.
